// File: rtl/proc_clock_gen.sv
// Derives the imem/dmem/processor/regfile phase clocks from the master clock,
// counts processor cycles and freezes the processor on a clean cycle boundary.
module proc_clock_gen #(
    parameter int DIV   = 4,
    parameter int PH_W  = 2,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             halt_req,
    output logic             imem_clock,
    output logic             dmem_clock,
    output logic             processor_clock,
    output logic             regfile_clock,
    output logic             proc_tick,
    output logic [PH_W-1:0]  phase,
    output logic [CNT_W-1:0] cycle_count,
    output logic             halted
);

    typedef enum logic [1:0] {
        RST   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [PH_W-1:0]  PH_ZERO = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]  PH_ONE  = {{(PH_W-1){1'b0}}, 1'b1};
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF = PH_W'(DIV / 2);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t          state_r;
    state_t          nextState_s;
    logic [PH_W-1:0] stepPhase_s;
    logic [PH_W-1:0] nextPhase_s;
    logic            live_s;
    logic            bump_s;

    // Packs {processor, regfile, imem, dmem, tick} for a given phase value.
    function automatic logic [4:0] decodePhase(input logic [PH_W-1:0] ph);
        logic pc;
        pc = (ph < PH_HALF);
        return {pc, ~pc, ~ph[0], ph[0], (ph == PH_ZERO)};
    endfunction

    // Next-state, next-phase and counter-bump selection.
    always_comb begin
        stepPhase_s = (phase == PH_LAST) ? PH_ZERO : (phase + PH_ONE);
        nextState_s = state_r;
        nextPhase_s = phase;
        live_s      = 1'b0;
        bump_s      = 1'b0;
        case (state_r)
            RST: begin
                nextState_s = RUN;
                nextPhase_s = PH_ZERO;
                live_s      = 1'b1;
                bump_s      = 1'b1;
            end
            RUN: begin
                if (halt_req && (phase == PH_LAST)) begin
                    nextState_s = HALT;
                    nextPhase_s = PH_LAST;
                end else begin
                    nextState_s = halt_req ? DRAIN : RUN;
                    nextPhase_s = stepPhase_s;
                    live_s      = 1'b1;
                    bump_s      = (stepPhase_s == PH_ZERO);
                end
            end
            // A committed halt ignores halt_req until the cycle completes.
            DRAIN: begin
                if (phase == PH_LAST) begin
                    nextState_s = HALT;
                    nextPhase_s = PH_LAST;
                end else begin
                    nextState_s = DRAIN;
                    nextPhase_s = stepPhase_s;
                    live_s      = 1'b1;
                    bump_s      = (stepPhase_s == PH_ZERO);
                end
            end
            HALT: begin
                if (halt_req) begin
                    nextState_s = HALT;
                    nextPhase_s = PH_LAST;
                end else begin
                    nextState_s = RUN;
                    nextPhase_s = PH_ZERO;
                    live_s      = 1'b1;
                    bump_s      = 1'b1;
                end
            end
            default: begin
                nextState_s = RST;
                nextPhase_s = PH_ZERO;
            end
        endcase
    end

    // State register with all outputs registered from the next-phase decode.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state_r         <= RST;
            phase           <= PH_ZERO;
            processor_clock <= 1'b0;
            regfile_clock   <= 1'b0;
            imem_clock      <= 1'b0;
            dmem_clock      <= 1'b0;
            proc_tick       <= 1'b0;
            cycle_count     <= {CNT_W{1'b0}};
            halted          <= 1'b0;
        end else begin
            state_r <= nextState_s;
            phase   <= nextPhase_s;
            {processor_clock, regfile_clock, imem_clock, dmem_clock, proc_tick}
                <= live_s ? decodePhase(nextPhase_s) : 5'b00000;
            cycle_count <= bump_s ? (cycle_count + CNT_ONE) : cycle_count;
            halted      <= (nextState_s == HALT);
        end
    end

endmodule

// File: tb/tb_proc_clock_gen.sv
// Directed and randomized checks of proc_clock_gen against a cycle-level
// behavioural model; a second instance with a 4-bit counter covers wrap-around.
module tb_proc_clock_gen;
    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic        halt_req = 1'b0;
    logic        imemClk, dmemClk, procClk, regClk, tick, haltedO;
    logic [1:0]  ph;
    logic [31:0] cnt;
    logic        imemClkW, dmemClkW, procClkW, regClkW, tickW, haltedW;
    logic [1:0]  phW;
    logic [3:0]  cntW;

    int tests = 0;
    int failed = 0;

    // Model: reset flag, halted flag, committed-halt flag, phase, count.
    bit          mReset = 1'b1;
    bit          mHalt = 1'b0;
    bit          mCommit = 1'b0;
    int          mPh = 0;
    logic [63:0] mCnt = 64'd0;

    proc_clock_gen #(.DIV(DIV), .PH_W(2), .CNT_W(32)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .halt_req(halt_req),
        .imem_clock(imemClk), .dmem_clock(dmemClk), .processor_clock(procClk),
        .regfile_clock(regClk), .proc_tick(tick), .phase(ph),
        .cycle_count(cnt), .halted(haltedO)
    );

    proc_clock_gen #(.DIV(DIV), .PH_W(2), .CNT_W(4)) dutW (
        .clock(clock), .ctrl_reset(ctrl_reset), .halt_req(halt_req),
        .imem_clock(imemClkW), .dmem_clock(dmemClkW), .processor_clock(procClkW),
        .regfile_clock(regClkW), .proc_tick(tickW), .phase(phW),
        .cycle_count(cntW), .halted(haltedW)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input logic rst, input logic hr);
        if (!rst) begin
            mReset = 1'b1; mHalt = 1'b0; mCommit = 1'b0; mPh = 0; mCnt = 64'd0;
        end else if (mReset) begin
            mReset = 1'b0; mPh = 0; mCnt = mCnt + 64'd1;
        end else if (mHalt) begin
            if (!hr) begin
                mHalt = 1'b0; mPh = 0; mCnt = mCnt + 64'd1;
            end
        end else begin
            if (hr) mCommit = 1'b1;
            if (mCommit && mPh == DIV - 1) begin
                mHalt = 1'b1; mCommit = 1'b0;
            end else begin
                mPh = (mPh + 1) % DIV;
                if (mPh == 0) mCnt = mCnt + 64'd1;
            end
        end
    endtask

    task automatic checkAll();
        bit live;
        live = !mReset && !mHalt;
        chk("pclk",   64'(procClk), 64'(live && mPh < DIV / 2));
        chk("rclk",   64'(regClk),  64'(live && mPh >= DIV / 2));
        chk("imem",   64'(imemClk), 64'(live && mPh % 2 == 0));
        chk("dmem",   64'(dmemClk), 64'(live && mPh % 2 == 1));
        chk("tick",   64'(tick),    64'(live && mPh == 0));
        chk("phase",  64'(ph),      64'(mPh));
        chk("count",  64'(cnt),     {32'd0, mCnt[31:0]});
        chk("halted", 64'(haltedO), 64'(mHalt));
        chk("countW", 64'(cntW),    {60'd0, mCnt[3:0]});
        chk("tickW",  64'(tickW),   64'(live && mPh == 0));
    endtask

    task automatic cyc(input logic rst, input logic hr);
        ctrl_reset = rst;
        halt_req   = hr;
        @(posedge clock);
        modelStep(rst, hr);
        #1;
        checkAll();
    endtask

    initial begin
        int ticks;
        logic hrLevel;

        // Reset and release
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
        chk("rstCnt", 64'(cnt), 64'd0);
        cyc(1'b1, 1'b0);
        chk("relPclk", 64'(procClk), 64'd1);
        chk("relImem", 64'(imemClk), 64'd1);
        chk("relCnt", 64'(cnt), 64'd1);
        ticks = 1;
        for (int i = 1; i < 16; i++) begin
            cyc(1'b1, 1'b0);
            if (tick) ticks++;
        end
        chk("run16Ticks", 64'(ticks), 64'd4);
        chk("run16Cnt", 64'(cnt), 64'd4);
        chk("run16Ph", 64'(ph), 64'd3);

        // Level halt raised at phase 1, held, then released
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("preHaltPh", 64'(ph), 64'd1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk("haltEntry", 64'(haltedO), 64'd1);
        chk("haltPh", 64'(ph), 64'd3);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
        chk("haltHoldCnt", 64'(cnt), 64'd5);
        cyc(1'b1, 1'b0);
        chk("resumeCnt", 64'(cnt), 64'd6);
        chk("resumePclk", 64'(procClk), 64'd1);

        // One-cycle pulse at phase 1 still commits the halt
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("pulseHalt", 64'(haltedO), 64'd1);
        cyc(1'b1, 1'b0);
        chk("pulseResume", 64'(haltedO), 64'd0);

        // Request at phase 3 halts immediately; reset during HALT and DRAIN
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("directHalt", 64'(haltedO), 64'd1);
        cyc(1'b0, 1'b1);
        chk("rstInHalt", 64'(haltedO), 64'd0);
        cyc(1'b1, 1'b1);
        chk("relIgnoresHalt", 64'(haltedO), 64'd0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        chk("rstInDrainCnt", 64'(cnt), 64'd0);

        // Narrow counter wrap over 16 processor cycles
        ticks = 0;
        for (int i = 0; i < 16 * DIV; i++) begin
            cyc(1'b1, 1'b0);
            if (tickW) begin
                ticks++;
                chk("wrapSeq", 64'(cntW), 64'(ticks % 16));
            end
        end
        chk("wrapTicks", 64'(ticks), 64'd16);

        // Randomized halt/reset traffic
        hrLevel = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) hrLevel = ~hrLevel;
            cyc(($urandom_range(0, 49) != 0), hrLevel);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
